// File: rtl/pulse_gen.sv
// pulse_gen: programmable pulse-train generator on the ALU command bus.
// Generates high/low phases of programmable length for a programmable
// number of pulses (0 = continuous), and reports status through the
// result-mux inputs when the OUT opcode is decoded.
module pulse_gen (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] dr0,
    input  logic [7:0] dr1,
    input  logic [7:0] cr,
    output logic       pulse_out,
    output logic [7:0] pulse_result,
    output logic [7:0] pulse_addition
);

    // Opcodes shared with the rest of the ALU command decoder.
    localparam logic [7:0] ALU_PULSE_SET   = 8'h40;
    localparam logic [7:0] ALU_PULSE_COUNT = 8'h41;
    localparam logic [7:0] ALU_PULSE_START = 8'h42;
    localparam logic [7:0] ALU_PULSE_STOP  = 8'h43;
    localparam logic [7:0] ALU_PULSE_OUT   = 8'h44;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HIGH = 2'b01,
        ST_LOW  = 2'b10,
        ST_BAD  = 2'b11
    } state_t;

    // A programmed length of 0 behaves as a 1-cycle phase.
    function automatic logic [7:0] eff_len(input logic [7:0] len);
        eff_len = (len == 8'd0) ? 8'd1 : len;
    endfunction

    state_t     state_r,    state_s;
    logic [7:0] high_r,     high_s;
    logic [7:0] low_r,      low_s;
    logic [7:0] num_r,      num_s;
    logic [7:0] remain_r,   remain_s;
    logic [7:0] phase_r,    phase_s;
    logic       done_r,     done_s;
    logic       start_d_r,  start_d_s;
    logic       pulse_r,    pulse_s;

    logic       is_start_s;
    logic       start_s;
    logic       is_stop_s;
    logic       is_out_s;
    logic       busy_s;

    assign is_start_s = (cr == ALU_PULSE_START);
    // Edge-detect START so a command held on the bus acts only once.
    assign start_s    = is_start_s && !start_d_r;
    assign is_stop_s  = (cr == ALU_PULSE_STOP);
    assign is_out_s   = (cr == ALU_PULSE_OUT);
    assign busy_s     = (state_r != ST_IDLE);

    // Next-state and next-register computation: start > stop > sequencing.
    always_comb begin
        state_s   = state_r;
        high_s    = high_r;
        low_s     = low_r;
        num_s     = num_r;
        remain_s  = remain_r;
        phase_s   = phase_r;
        done_s    = done_r;
        pulse_s   = pulse_r;
        start_d_s = is_start_s;

        if (cr == ALU_PULSE_SET) begin
            high_s = dr0;
            low_s  = dr1;
        end else if (cr == ALU_PULSE_COUNT) begin
            num_s = dr0;
        end else begin
            high_s = high_r;
        end

        if (start_s) begin
            state_s  = ST_HIGH;
            pulse_s  = 1'b1;
            phase_s  = eff_len(high_r) - 8'd1;
            remain_s = num_r;
            done_s   = 1'b0;
        end else if (is_stop_s) begin
            state_s = ST_IDLE;
            pulse_s = 1'b0;
            done_s  = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_IDLE;
                end
                ST_HIGH: begin
                    if (phase_r != 8'd0) begin
                        phase_s = phase_r - 8'd1;
                    end else begin
                        state_s = ST_LOW;
                        pulse_s = 1'b0;
                        phase_s = eff_len(low_r) - 8'd1;
                    end
                end
                ST_LOW: begin
                    if (phase_r != 8'd0) begin
                        phase_s = phase_r - 8'd1;
                    end else if ((num_r != 8'd0) && (remain_r == 8'd1)) begin
                        state_s  = ST_IDLE;
                        remain_s = 8'd0;
                        done_s   = 1'b1;
                    end else begin
                        state_s = ST_HIGH;
                        pulse_s = 1'b1;
                        phase_s = eff_len(high_r) - 8'd1;
                        // Guarded so a COUNT rewritten mid-train cannot wrap.
                        if ((num_r != 8'd0) && (remain_r != 8'd0)) begin
                            remain_s = remain_r - 8'd1;
                        end else begin
                            remain_s = remain_r;
                        end
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    pulse_s = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            high_r    <= 8'd0;
            low_r     <= 8'd0;
            num_r     <= 8'd0;
            remain_r  <= 8'd0;
            phase_r   <= 8'd0;
            done_r    <= 1'b0;
            start_d_r <= 1'b0;
            pulse_r   <= 1'b0;
        end else begin
            state_r   <= state_s;
            high_r    <= high_s;
            low_r     <= low_s;
            num_r     <= num_s;
            remain_r  <= remain_s;
            phase_r   <= phase_s;
            done_r    <= done_s;
            start_d_r <= start_d_s;
            pulse_r   <= pulse_s;
        end
    end

    assign pulse_out = pulse_r;

    // Status readback only while OUT is on the bus, zero otherwise.
    always_comb begin
        if (is_out_s) begin
            pulse_result   = remain_r;
            pulse_addition = {6'h00, busy_s, done_r};
        end else begin
            pulse_result   = 8'h00;
            pulse_addition = 8'h00;
        end
    end

endmodule

// File: tb/tb_pulse_gen.sv
// Directed self-checking bench for pulse_gen. Inputs change on the falling
// edge; outputs are read 1 time unit later, well away from the rising edge.
module tb_pulse_gen;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_SET   = 8'h40;
    localparam logic [7:0] OP_COUNT = 8'h41;
    localparam logic [7:0] OP_START = 8'h42;
    localparam logic [7:0] OP_STOP  = 8'h43;
    localparam logic [7:0] OP_OUT   = 8'h44;

    logic       clk;
    logic       rst_n;
    logic [7:0] dr0;
    logic [7:0] dr1;
    logic [7:0] cr;
    logic       pulse_out;
    logic [7:0] pulse_result;
    logic [7:0] pulse_addition;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    pulse_gen dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .dr0            (dr0),
        .dr1            (dr1),
        .cr             (cr),
        .pulse_out      (pulse_out),
        .pulse_result   (pulse_result),
        .pulse_addition (pulse_addition)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmd(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        cr  = op;
        dr0 = a;
        dr1 = b;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cr    = OP_OUT;
        dr0   = 8'h00;
        dr1   = 8'h00;
        #3;
        chk_cnt++;
        if (pulse_out !== 1'b0) $display("FAIL reset_pulse_out got=%b exp=0", pulse_out);
        else pass_cnt++;
        chk_cnt++;
        if (pulse_result !== 8'h00) $display("FAIL reset_result got=%h exp=00", pulse_result);
        else pass_cnt++;
        chk_cnt++;
        if (pulse_addition !== 8'h00) $display("FAIL reset_addition got=%h exp=00", pulse_addition);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        cr    = OP_NOP;
    endtask

    task automatic test_basic_train();
        logic [9:0] pat;
        pat = 10'b1110011100;
        cmd(OP_SET, 8'd3, 8'd2);
        cmd(OP_COUNT, 8'd2, 8'd0);
        cmd(OP_START, 8'd0, 8'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cr = (i == 0) ? OP_OUT : OP_NOP;
            #1;
            chk_cnt++;
            if (pulse_out !== pat[9 - i])
                $display("FAIL basic_pulse[%0d] got=%b exp=%b", i, pulse_out, pat[9 - i]);
            else pass_cnt++;
            if (i == 0) begin
                chk_cnt++;
                if (pulse_result !== 8'd2) $display("FAIL basic_first_result got=%h exp=02", pulse_result);
                else pass_cnt++;
                chk_cnt++;
                if (pulse_addition !== 8'h02) $display("FAIL basic_first_addition got=%h exp=02", pulse_addition);
                else pass_cnt++;
            end
        end
        @(negedge clk);
        cr = OP_OUT;
        #1;
        chk_cnt++;
        if (pulse_result !== 8'd0) $display("FAIL basic_end_result got=%h exp=00", pulse_result);
        else pass_cnt++;
        chk_cnt++;
        if (pulse_addition !== 8'h01) $display("FAIL basic_end_addition got=%h exp=01", pulse_addition);
        else pass_cnt++;
        chk_cnt++;
        if (pulse_out !== 1'b0) $display("FAIL basic_end_pulse got=%b exp=0", pulse_out);
        else pass_cnt++;
        cmd(OP_NOP, 8'd0, 8'd0);
        // Readback must vanish when OUT leaves the bus.
        #1;
        chk_cnt++;
        if (pulse_addition !== 8'h00) $display("FAIL basic_nop_addition got=%h exp=00", pulse_addition);
        else pass_cnt++;
    endtask

    task automatic test_zero_len_held_start();
        logic [5:0] pat;
        pat = 6'b101010;
        cmd(OP_SET, 8'd0, 8'd0);
        cmd(OP_COUNT, 8'd3, 8'd0);
        cmd(OP_START, 8'd0, 8'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i < 3) cr = OP_START;
            else if (i == 5) cr = OP_OUT;
            else cr = OP_NOP;
            #1;
            chk_cnt++;
            if (pulse_out !== pat[5 - i])
                $display("FAIL zero_pulse[%0d] got=%b exp=%b", i, pulse_out, pat[5 - i]);
            else pass_cnt++;
        end
        chk_cnt++;
        if (pulse_addition !== 8'h02) $display("FAIL zero_last_addition got=%h exp=02", pulse_addition);
        else pass_cnt++;
        chk_cnt++;
        if (pulse_result !== 8'd1) $display("FAIL zero_last_result got=%h exp=01", pulse_result);
        else pass_cnt++;
        @(negedge clk);
        cr = OP_OUT;
        #1;
        chk_cnt++;
        if (pulse_addition !== 8'h01) $display("FAIL zero_done_addition got=%h exp=01", pulse_addition);
        else pass_cnt++;
        chk_cnt++;
        if (pulse_result !== 8'd0) $display("FAIL zero_done_result got=%h exp=00", pulse_result);
        else pass_cnt++;
        cmd(OP_NOP, 8'd0, 8'd0);
    endtask

    task automatic test_continuous_stop();
        int bad;
        bad = 0;
        cmd(OP_SET, 8'd1, 8'd1);
        cmd(OP_COUNT, 8'd0, 8'd0);
        cmd(OP_START, 8'd0, 8'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cr = (i == 17) ? OP_OUT : OP_NOP;
            #1;
            chk_cnt++;
            if (pulse_out !== ((i % 2) == 0)) begin
                $display("FAIL cont_pulse[%0d] got=%b exp=%b", i, pulse_out, ((i % 2) == 0));
                bad++;
            end else pass_cnt++;
            if (i == 17) begin
                chk_cnt++;
                if ((pulse_result !== 8'd0) || (pulse_addition !== 8'h02))
                    $display("FAIL cont_status got=%h/%h exp=00/02", pulse_result, pulse_addition);
                else pass_cnt++;
            end
        end
        cmd(OP_STOP, 8'd0, 8'd0);
        @(negedge clk);
        cr = OP_OUT;
        #1;
        chk_cnt++;
        if (pulse_out !== 1'b0) $display("FAIL stop_pulse got=%b exp=0", pulse_out);
        else pass_cnt++;
        chk_cnt++;
        if (pulse_addition !== 8'h00) $display("FAIL stop_addition got=%h exp=00", pulse_addition);
        else pass_cnt++;
        chk_cnt++;
        if (pulse_result !== 8'd0) $display("FAIL stop_result got=%h exp=00", pulse_result);
        else pass_cnt++;
        cmd(OP_NOP, 8'd0, 8'd0);
    endtask

    task automatic test_restart_live_set();
        logic [5:0] pat;
        pat = 6'b111101;
        cmd(OP_SET, 8'd4, 8'd4);
        cmd(OP_COUNT, 8'd5, 8'd0);
        cmd(OP_START, 8'd0, 8'd0);
        // Samples after edges 1..6: four-cycle HIGH, then a single LOW (L=1).
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) begin
                cr  = OP_SET;
                dr0 = 8'd1;
                dr1 = 8'd1;
            end else if (i == 5) begin
                cr = OP_START;
            end else begin
                cr = OP_NOP;
            end
            #1;
            chk_cnt++;
            if (pulse_out !== pat[5 - i])
                $display("FAIL restart_pulse[%0d] got=%b exp=%b", i, pulse_out, pat[5 - i]);
            else pass_cnt++;
        end
        @(negedge clk);
        cr = OP_OUT;
        #1;
        chk_cnt++;
        if (pulse_result !== 8'd5) $display("FAIL restart_result got=%h exp=05", pulse_result);
        else pass_cnt++;
        chk_cnt++;
        if (pulse_out !== 1'b1) $display("FAIL restart_high got=%b exp=1", pulse_out);
        else pass_cnt++;
        @(negedge clk);
        cr = OP_NOP;
        #1;
        chk_cnt++;
        if (pulse_out !== 1'b0) $display("FAIL restart_short_high got=%b exp=0", pulse_out);
        else pass_cnt++;
        cmd(OP_STOP, 8'd0, 8'd0);
        cmd(OP_NOP, 8'd0, 8'd0);
    endtask

    task automatic test_reset_mid_pulse();
        cmd(OP_SET, 8'd3, 8'd2);
        cmd(OP_COUNT, 8'd0, 8'd0);
        cmd(OP_START, 8'd0, 8'd0);
        @(negedge clk);
        cr = OP_NOP;
        #1;
        chk_cnt++;
        if (pulse_out !== 1'b1) $display("FAIL rstmid_before got=%b exp=1", pulse_out);
        else pass_cnt++;
        #1;
        rst_n = 1'b0;
        #1;
        chk_cnt++;
        if (pulse_out !== 1'b0) $display("FAIL rstmid_async got=%b exp=0", pulse_out);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        cr    = OP_OUT;
        #1;
        chk_cnt++;
        if ((pulse_result !== 8'd0) || (pulse_addition !== 8'h00))
            $display("FAIL rstmid_status got=%h/%h exp=00/00", pulse_result, pulse_addition);
        else pass_cnt++;
        repeat (4) @(negedge clk);
        #1;
        chk_cnt++;
        if ((pulse_out !== 1'b0) || (pulse_addition !== 8'h00))
            $display("FAIL rstmid_idle got=%b/%h exp=0/00", pulse_out, pulse_addition);
        else pass_cnt++;
        cr = OP_NOP;
    endtask

    initial begin
        test_reset();
        test_basic_train();
        test_zero_len_held_start();
        test_continuous_stop();
        test_restart_live_set();
        test_reset_mid_pulse();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/pulse_gen.md
# pulse_gen

Programmable pulse generator for the microcontroller core. The counter block counts incoming trigger events; this block produces events: a pulse train on `pulse_out` with programmable high time, low time and pulse count. It sits beside the counter on the ALU command bus `cr`, takes operands from `dr0`/`dr1`, and returns status through the result-mux inputs `pulse_result`/`pulse_addition`.

## Interface
- No module parameters; all data widths are `` `DATA_WIDTH `` (8) from `define.v`.
- New opcodes in `define.v`: `` `ALU_PULSE_SET ``, `` `ALU_PULSE_COUNT ``, `` `ALU_PULSE_START ``, `` `ALU_PULSE_STOP ``, `` `ALU_PULSE_OUT ``.

Ports:
- `clk`  in  1  core clock; the only clock in the block.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `dr0`  in  DATA_WIDTH  operand: high length for SET, pulse count for COUNT.
- `dr1`  in  DATA_WIDTH  operand: low length for SET.
- `cr`  in  DATA_WIDTH  ALU command code.
- `pulse_out`  out  1  registered pulse output.
- `pulse_result`  out  DATA_WIDTH  remaining-pulse count while OUT is decoded, else 0.
- `pulse_addition`  out  DATA_WIDTH  `{6'h00, busy, done}` while OUT is decoded, else 0.

## Operation
Registers:
- `reg_high`, `reg_low`, `reg_num`, `reg_remain`, `reg_phase` (all 8-bit).
- `reg_done`, `reg_start_d`, `pulse_out`.
- State: IDLE=2'b00, HIGH=2'b01, LOW=2'b10. Code 2'b11 returns to IDLE.

Command decode:
- `start = (cr==START) && !reg_start_d`, where `reg_start_d <= (cr==START)`. A START held on `cr` for several cycles acts once.
- SET: `reg_high<=dr0`, `reg_low<=dr1`. Allowed in any state. New values take effect at the next phase load; the phase in progress keeps its length.
- COUNT: `reg_num<=dr0`. 0 means continuous. `reg_remain` is not touched.
- STOP: go to IDLE, `pulse_out<=0`, `reg_done<=0`, `reg_remain` holds its value.
- OUT: drives the outputs combinationally; no state change.

Effective lengths: `H = (reg_high==0) ? 1 : reg_high`. `L` is formed the same way from `reg_low`.

Transitions:
- `start` from any state (including a restart from HIGH or LOW):
  - state→HIGH, `pulse_out<=1`, `reg_phase<=H-1`, `reg_remain<=reg_num`, `reg_done<=0`.
- HIGH:
  - `reg_phase!=0`: decrement.
  - `reg_phase==0`: state→LOW, `pulse_out<=0`, `reg_phase<=L-1`.
- LOW:
  - `reg_phase!=0`: decrement.
  - `reg_phase==0` and `reg_num!=0` and `reg_remain==1`: state→IDLE, `reg_remain<=0`, `reg_done<=1`.
  - `reg_phase==0` otherwise: state→HIGH, `pulse_out<=1`, `reg_phase<=H-1`. If `reg_num!=0`, `reg_remain<=reg_remain-1`.
- Priority when commands coincide: `start` > STOP > phase sequencing. SET and COUNT register updates happen in parallel with all of these.
- `busy = (state!=IDLE)`.
- In continuous mode `reg_remain` stays 0. No counter wraps; phase counters only decrement to 0.

## Timing
- Reset (asynchronous, `rst_n` low): all registers are 0 and state is IDLE. `pulse_out=0`, `pulse_result=0`, `pulse_addition=0` immediately, with no clock needed.
- Reset asserted mid-train: `pulse_out` drops at once. After release the block stays in IDLE until a new START.
- START decoded before clock edge E: `pulse_out` rises after E. It is high for exactly H cycles, then low for exactly L cycles, so the period is H+L.
- Finite train: `done`=1 from the edge that ends the last LOW phase. `done` stays 1 until the next `start`, STOP or reset.
- STOP before edge E: `pulse_out` is 0 after E.
- `pulse_result` and `pulse_addition` are combinational from `cr` and the registers, with zero latency. They are 0 whenever `cr!=OUT`.

## Test plan
- Reset mid-pulse: SET(3,2), COUNT(0), START, then assert `rst_n` low while `pulse_out`=1. Required: `pulse_out`=0 asynchronously; after release, OUT reads result 0 and addition 0.
- Basic train: SET(dr0=3,dr1=2), COUNT(dr0=2), START. Required: `pulse_out` pattern 1,1,1,0,0,1,1,1,0,0. Then IDLE; OUT gives result=0, addition=8'h01. During the first pulse OUT gives result=2, addition=8'h02.
- Zero lengths and START held: SET(0,0), COUNT(3), with START on `cr` for 4 cycles. Required: single start; `pulse_out` toggles every cycle (1,0,1,0,1,0); `done` set after the 6th cycle.
- Continuous plus STOP: SET(1,1), COUNT(0), START, let 20 cycles run, then STOP. Required: continuous 1,0 alternation during the run. After STOP, `pulse_out`=0, addition=8'h00, result=0.
- Restart and live SET: SET(4,4), COUNT(5), START. In cycle 2 issue SET(1,1); in cycle 6 issue START. Required: first HIGH lasts 4 cycles; the LOW phase loaded at that edge uses L=1. The second START reloads `reg_remain`=5 with a fresh 1-cycle HIGH. OUT shows result=5 at that point.
